// File: rtl/rd_data_steer.sv
// Read-side data steering: delays the last-writer select to line up with the RAM bank
// read data, muxes the selected bank and buffers it in a credit-protected output FIFO.
// Optional out-of-range select check enabled by defining RD_DATA_STEER_CHECK_EN.
module rd_data_steer #(
    parameter int DATA_WIDTH   = 8,
    parameter int NB_WRAGENT   = 2,
    parameter int SELECT_WIDTH = (NB_WRAGENT == 1) ? 1 : $clog2(NB_WRAGENT),
    parameter int RAM_LATENCY  = 1,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                             aclk,
    input  logic                             areset,
    input  logic                             rden,
    output logic                             rdready_o,
    input  logic [SELECT_WIDTH-1:0]          rdselect,
    input  logic [NB_WRAGENT*DATA_WIDTH-1:0] bank_rddata,
    output logic                             rdvalid,
    input  logic                             rdready,
    output logic [DATA_WIDTH-1:0]            rddata,
    output logic                             steer_err
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;

    logic                    accept;
    logic                    pop;
    logic [CW-1:0]           credits;
    logic [CW-1:0]           credits_next;

    logic [RAM_LATENCY-1:0]  pipe_vld;
    logic [SELECT_WIDTH-1:0] pipe_sel [RAM_LATENCY];
    logic                    out_vld;
    logic [SELECT_WIDTH-1:0] out_sel;
    logic [DATA_WIDTH-1:0]   steer_word;

    logic                    st_vld;
    logic [DATA_WIDTH-1:0]   st_data;

    logic [DATA_WIDTH-1:0]   mem [FIFO_DEPTH];
    logic [AW:0]             wr_ptr;
    logic [AW:0]             rd_ptr;

    assign accept = rden & rdready_o;
    assign pop    = rdvalid & rdready;

    // One credit per FIFO slot; a credit is held from acceptance until the word is popped.
    always_comb begin
        credits_next = credits;
        if (accept && !pop) begin
            credits_next = credits - CW'(1);
        end else if (pop && !accept) begin
            credits_next = credits + CW'(1);
        end
    end

    // rdready_o is registered so it stays low throughout reset and rises one edge after release.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            credits   <= CW'(FIFO_DEPTH);
            rdready_o <= 1'b0;
        end else begin
            credits   <= credits_next;
            rdready_o <= (credits_next != '0);
        end
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            pipe_vld <= '0;
            for (int i = 0; i < RAM_LATENCY; i++) begin
                pipe_sel[i] <= '0;
            end
        end else begin
            pipe_vld[0] <= accept;
            pipe_sel[0] <= rdselect;
            for (int i = 1; i < RAM_LATENCY; i++) begin
                pipe_vld[i] <= pipe_vld[i-1];
                pipe_sel[i] <= pipe_sel[i-1];
            end
        end
    end

    assign out_vld = pipe_vld[RAM_LATENCY-1];
    assign out_sel = pipe_sel[RAM_LATENCY-1];

    // An unmatched select leaves the word at zero.
    always_comb begin
        steer_word = '0;
        for (int k = 0; k < NB_WRAGENT; k++) begin
            if (NB_WRAGENT == 1 || out_sel == SELECT_WIDTH'(k)) begin
                steer_word = bank_rddata[k*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    // Steered word is registered before the FIFO so bank_rddata never reaches rddata combinationally.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            st_vld  <= 1'b0;
            st_data <= '0;
        end else begin
            st_vld <= out_vld;
            if (out_vld) begin
                st_data <= steer_word;
            end
        end
    end

`ifdef RD_DATA_STEER_CHECK_EN
    logic sel_ok;

    always_comb begin
        sel_ok = 1'b0;
        for (int k = 0; k < NB_WRAGENT; k++) begin
            if (NB_WRAGENT == 1 || out_sel == SELECT_WIDTH'(k)) begin
                sel_ok = 1'b1;
            end
        end
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            steer_err <= 1'b0;
        end else if (out_vld && !sel_ok) begin
            steer_err <= 1'b1;
        end
    end
`else
    assign steer_err = 1'b0;
`endif

    // Credits bound the occupancy, so no full/empty guards are needed on write or pop.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (st_vld) begin
                mem[wr_ptr[AW-1:0]] <= st_data;
                wr_ptr              <= wr_ptr + (AW+1)'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + (AW+1)'(1);
            end
        end
    end

    assign rdvalid = (wr_ptr != rd_ptr);
    assign rddata  = mem[rd_ptr[AW-1:0]];

endmodule

// File: tb/tb_rd_data_steer.sv
// Directed bench for rd_data_steer: default instance (2 banks, latency 1, depth 4) plus a
// 3-bank instance for the select check; define RD_DATA_STEER_CHECK_EN to cover the error flag.
module tb_rd_data_steer;

    logic        aclk;
    logic        areset;
    logic        rden;
    logic        rdready_o;
    logic [0:0]  rdselect;
    logic [15:0] bank_rddata;
    logic        rdvalid;
    logic        rdready;
    logic [7:0]  rddata;
    logic        steer_err;

    logic        rden3;
    logic        rdready_o3;
    logic [1:0]  sel3;
    logic [23:0] bank3;
    logic        rdvalid3;
    logic        rdready3;
    logic [7:0]  rddata3;
    logic        steer_err3;

    int tests = 0;
    int fails = 0;

    rd_data_steer #(
        .DATA_WIDTH (8),
        .NB_WRAGENT (2),
        .RAM_LATENCY(1),
        .FIFO_DEPTH (4)
    ) dut (
        .aclk       (aclk),
        .areset     (areset),
        .rden       (rden),
        .rdready_o  (rdready_o),
        .rdselect   (rdselect),
        .bank_rddata(bank_rddata),
        .rdvalid    (rdvalid),
        .rdready    (rdready),
        .rddata     (rddata),
        .steer_err  (steer_err)
    );

    rd_data_steer #(
        .DATA_WIDTH (8),
        .NB_WRAGENT (3),
        .RAM_LATENCY(1),
        .FIFO_DEPTH (4)
    ) u_dut3 (
        .aclk       (aclk),
        .areset     (areset),
        .rden       (rden3),
        .rdready_o  (rdready_o3),
        .rdselect   (sel3),
        .bank_rddata(bank3),
        .rdvalid    (rdvalid3),
        .rdready    (rdready3),
        .rddata     (rddata3),
        .steer_err  (steer_err3)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge aclk);
        #1;
    endtask

    initial begin
        int          idx;
        int          first;
        int          last;
        logic [7:0]  e;

        areset      = 1'b1;
        rden        = 1'b0;
        rdselect    = '0;
        bank_rddata = '0;
        rdready     = 1'b1;
        rden3       = 1'b0;
        sel3        = '0;
        bank3       = '0;
        rdready3    = 1'b1;

        // reset values
        step();
        step();
        chk("rst_rdready_o", rdready_o, 0);
        chk("rst_rdvalid", rdvalid, 0);
        chk("rst_rddata", rddata, 0);
        chk("rst_steer_err", steer_err, 0);

        // release
        areset = 1'b0;
        #2;
        chk("rel_cycle0_rdready_o", rdready_o, 0);
        chk("rel_cycle0_rdvalid", rdvalid, 0);
        step();
        chk("rel_cycle1_rdready_o", rdready_o, 1);
        chk("rel_credits", dut.credits, 4);
        chk("rel_rdready_o3", rdready_o3, 1);

        // single request, select bank 1
        bank_rddata = 16'hB1A0;
        rden        = 1'b1;
        rdselect    = 1'b1;
        step();
        rden     = 1'b0;
        rdselect = 1'b0;
        chk("single_t0_rdvalid", rdvalid, 0);
        chk("single_t0_rdready_o", rdready_o, 1);
        step();
        chk("single_t1_rdvalid", rdvalid, 0);
        chk("single_t1_rdready_o", rdready_o, 1);
        step();
        chk("single_t2_rdvalid", rdvalid, 1);
        chk("single_t2_rddata", rddata, 8'hB1);
        chk("single_t2_rdready_o", rdready_o, 1);
        step();
        chk("single_drained", rdvalid, 0);

        // 8 back-to-back requests, alternating selects
        idx   = 0;
        first = -1;
        last  = -1;
        for (int c = 0; c < 14; c++) begin
            rden        = (c < 8);
            rdselect    = c[0];
            bank_rddata = {8'h20 + 8'(c - 1), 8'h10 + 8'(c - 1)};
            step();
            if (rdvalid) begin
                e = (idx % 2 == 1) ? 8'(32'h20 + idx) : 8'(32'h10 + idx);
                chk("b2b_data", rddata, e);
                if (first < 0) first = c;
                last = c;
                idx++;
            end
            chk("b2b_rdready_o", rdready_o, 1);
        end
        rden = 1'b0;
        chk("b2b_count", idx, 8);
        chk("b2b_no_gap", last - first, 7);

        // backpressure: 6 attempts, only 4 credits
        rdready = 1'b0;
        for (int c = 0; c < 9; c++) begin
            rden        = (c < 6);
            rdselect    = c[0];
            bank_rddata = {8'h40 + 8'(c - 1), 8'h30 + 8'(c - 1)};
            step();
            chk("bp_rdready_o", rdready_o, (c < 3) ? 1 : 0);
        end
        rden = 1'b0;
        chk("bp_rdvalid", rdvalid, 1);
        chk("bp_head0", rddata, 8'h30);
        chk("bp_credits_zero", dut.credits, 0);
        rdready = 1'b1;
        step();
        rdready = 1'b0;
        chk("bp_pop_rdready_o", rdready_o, 1);
        chk("bp_head1", rddata, 8'h41);
        step();
        chk("bp_hold_rdvalid", rdvalid, 1);
        chk("bp_hold_rddata", rddata, 8'h41);
        rdready = 1'b1;
        step();
        chk("bp_head2", rddata, 8'h32);
        step();
        chk("bp_head3", rddata, 8'h43);
        step();
        chk("bp_drained", rdvalid, 0);
        chk("bp_credits_back", dut.credits, 4);

        // reset with two requests in flight and one buffered
        rdready     = 1'b0;
        bank_rddata = 16'h5A5A;
        rden        = 1'b1;
        rdselect    = 1'b0;
        step();
        step();
        step();
        rden = 1'b0;
        chk("rstmid_pre_rdvalid", rdvalid, 1);
        areset = 1'b1;
        #1;
        chk("rstmid_rdvalid", rdvalid, 0);
        chk("rstmid_rdready_o", rdready_o, 0);
        step();
        areset  = 1'b0;
        rdready = 1'b1;
        step();
        chk("rstmid_rel_rdready_o", rdready_o, 1);
        chk("rstmid_credits", dut.credits, 4);
        for (int c = 0; c < 6; c++) begin
            step();
            chk("rstmid_no_stale", rdvalid, 0);
        end

        // 3-bank instance: out-of-range select followed by select 2
        bank3 = 24'hC2B1A0;
        rden3 = 1'b1;
        sel3  = 2'd3;
        step();
        sel3 = 2'd2;
        step();
        rden3 = 1'b0;
        sel3  = 2'd0;
        step();
        chk("n3_word0_rdvalid", rdvalid3, 1);
`ifdef RD_DATA_STEER_CHECK_EN
        chk("n3_oor_rddata", rddata3, 0);
        chk("n3_steer_err_set", steer_err3, 1);
`else
        chk("n3_steer_err_tied", steer_err3, 0);
`endif
        step();
        chk("n3_word1_rdvalid", rdvalid3, 1);
        chk("n3_bank2_rddata", rddata3, 8'hC2);
`ifdef RD_DATA_STEER_CHECK_EN
        chk("n3_steer_err_sticky", steer_err3, 1);
`else
        chk("n3_steer_err_still0", steer_err3, 0);
`endif
        step();
        chk("n3_drained", rdvalid3, 0);
        chk("n3_credits", u_dut3.credits, 4);
        chk("n3_main_steer_err", steer_err, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
